// File: rtl/slc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_pkg
//  Description : Shared definitions for the memory responder: responder state
//                encoding and the memory-mapped I/O address.
//  Revision    : 1.0 - initial release
// ============================================================================
package slc3_pkg;

    // Responder state encoding (fixed two-bit codes kept for legacy tooling)
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACCESS = 2'd1;
    localparam logic [1:0] C_ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = C_ST_IDLE,
        ACCESS = C_ST_ACCESS,
        RESP   = C_ST_RESP
    } state_e;

    // Address decoded as switch/hex-display I/O when memory-mapped I/O is built in
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

endpackage : slc3_pkg
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wait_counter
//  Description : Access wait-state counter. 'load' clears the count, 'enable'
//                advances it, and it stops at 'terminal' so it never wraps
//                inside an access. 'tc' flags the terminal count.
//  Ports       : clk, rst (sync, active-high), load, enable, terminal[WIDTH],
//                tc (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
        end else if (enable && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == terminal);

endmodule : wait_counter
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : CPU-to-SRAM access responder. Accepts one request in IDLE,
//                drives the SRAM for WAIT_CYCLES+1 ACCESS cycles, then holds
//                the response in RESP until the CPU takes it.
//  Ports       : Clk, Reset (sync, active-high)
//                req_valid/req_we/req_addr/req_wdata/req_ready  - request side
//                rsp_valid/rsp_ready/rsp_rdata                  - response side
//                mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata     - SRAM side
//                sw_in/hex_out (only with MEM_RESP_IOMAP_EN)     - mapped I/O
//  Config      : `define MEM_RESP_IOMAP_EN maps IO_ADDR to sw_in (read) and
//                hex_out (write) instead of SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import slc3_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_RESP_IOMAP_EN
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] hex_out,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int C_CNT_W = 4;

    state_e            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic              w_in_access;
    logic              w_tc;
    logic              w_is_io;
    logic [DATA_W-1:0] w_rd_src;

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_in_access = (r_state == ACCESS);

`ifdef MEM_RESP_IOMAP_EN
    assign w_is_io  = (r_addr == ADDR_W'(IO_ADDR));
    assign w_rd_src = w_is_io ? sw_in : mem_rdata;
`else
    assign w_is_io  = 1'b0;
    assign w_rd_src = mem_rdata;
`endif

    wait_counter #(
        .WIDTH    (C_CNT_W)
    ) u_wait_counter (
        .clk      (Clk),
        .rst      (Reset),
        .load     (w_accept),
        .enable   (w_in_access),
        .terminal (C_CNT_W'(WAIT_CYCLES)),
        .tc       (w_tc)
    );

    // The request is captured only on acceptance, so req_* activity during
    // ACCESS/RESP cannot disturb the access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_tc) begin
                        // Write acknowledges carry zero data
                        r_rdata <= r_we ? '0 : w_rd_src;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESP_IOMAP_EN
    logic [DATA_W-1:0] r_hex;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hex <= '0;
        end else if (w_in_access && w_tc && r_we && w_is_io) begin
            r_hex <= r_wdata;
        end
    end

    assign hex_out = r_hex;
`endif

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    // The SRAM is left idle for I/O-mapped accesses
    assign mem_ce    = w_in_access && !w_is_io;
    assign mem_we    = w_in_access && r_we && !w_is_io;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. One instance uses
//                WAIT_CYCLES=2, a second uses WAIT_CYCLES=0 for back-to-back
//                timing. The bench plays the SRAM from its own array, and
//                presents valid read data only on the final ACCESS cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int WC = 2;

    logic        Clk = 1'b0;
    logic        Reset;

    // WAIT_CYCLES = 2 instance
    logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_addr, req_wdata, rsp_rdata;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_RESP_IOMAP_EN
    logic [15:0] sw_in, hex_out;
`endif

    // WAIT_CYCLES = 0 instance
    logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic        b_mem_ce, b_mem_we;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef MEM_RESP_IOMAP_EN
    logic [15:0] b_sw_in, b_hex_out;
`endif

    logic [15:0] sram [0:65535];
    logic [15:0] sw_val_next;
    int          n_pass   = 0;
    int          n_checks = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(WC)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef MEM_RESP_IOMAP_EN
        .sw_in(sw_in), .hex_out(hex_out),
`endif
        .mem_rdata(mem_rdata)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata),
`ifdef MEM_RESP_IOMAP_EN
        .sw_in(b_sw_in), .hex_out(b_hex_out),
`endif
        .mem_rdata(b_mem_rdata)
    );

    // One complete transaction on the WAIT_CYCLES=2 instance, starting and
    // ending at a falling edge with the responder idle. 'hold' is the number
    // of RESP cycles with rsp_ready low before it is raised.
    task automatic do_access(input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata, input int hold);
        logic        io;
        logic [15:0] exp_rd;
        logic [35:0] got_a, exp_a;
        logic [19:0] got_r, exp_r;
        logic [3:0]  got_i;
        io = 1'b0;
`ifdef MEM_RESP_IOMAP_EN
        io = (addr == 16'hFFFF);
`endif
        exp_rd = 16'h0;
        if (!we && !io) exp_rd = sram[addr];

        n_checks++;
        if (req_ready !== 1'b1)
            $display("FAIL accept_ready got=%b exp=1", req_ready);
        else n_pass++;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge Clk);

        for (int k = 0; k <= WC; k++) begin
            got_a = {req_ready, rsp_valid, mem_ce, mem_we, mem_addr, mem_wdata};
            exp_a = {1'b0, 1'b0, ~io, we & ~io, addr, wdata};
            n_checks++;
            if (got_a !== exp_a)
                $display("FAIL access_cycle%0d {rdy,vld,ce,we,addr,wdata} got=%h exp=%h",
                         k, got_a, exp_a);
            else n_pass++;
            // Scramble the request side; it must not affect this access
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
            rsp_ready = 1'($urandom);
            mem_rdata = (k == WC) ? sram[addr] : 16'($urandom);
`ifdef MEM_RESP_IOMAP_EN
            sw_in = (k == WC) ? sw_val_next : 16'($urandom);
            if (io && !we) exp_rd = sw_val_next;
`endif
            @(negedge Clk);
        end
        if (we && !io) sram[addr] = wdata;

        for (int d = 0; d <= hold; d++) begin
            got_r = {req_ready, rsp_valid, mem_ce, mem_we, rsp_rdata};
            exp_r = {1'b0, 1'b1, 1'b0, 1'b0, exp_rd};
            n_checks++;
            if (got_r !== exp_r)
                $display("FAIL resp_cycle%0d {rdy,vld,ce,we,rdata} got=%h exp=%h",
                         d, got_r, exp_r);
            else n_pass++;
            req_valid = (d == hold) ? 1'b0 : 1'($urandom);
            req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
            rsp_ready = (d == hold);
            mem_rdata = 16'($urandom);
            @(negedge Clk);
        end
        rsp_ready = 1'b0;

        got_i = {req_ready, rsp_valid, mem_ce, mem_we};
        n_checks++;
        if (got_i !== 4'b1000)
            $display("FAIL back_to_idle {rdy,vld,ce,we} got=%b exp=1000", got_i);
        else n_pass++;
`ifdef MEM_RESP_IOMAP_EN
        if (io && we) begin
            n_checks++;
            if (hex_out !== wdata)
                $display("FAIL hex_out got=%h exp=%h", hex_out, wdata);
            else n_pass++;
        end
`endif
    endtask

    task automatic test_reset();
        logic [35:0] got;
        Reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        rsp_ready = 1'b0; mem_rdata = 16'h0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0;
        b_rsp_ready = 1'b0; b_mem_rdata = 16'h0;
`ifdef MEM_RESP_IOMAP_EN
        sw_in = 16'h0; b_sw_in = 16'h0;
`endif
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        got = {req_ready, rsp_valid, mem_ce, mem_we, mem_addr, mem_wdata};
        n_checks++;
        if (got !== {4'b1000, 32'h0})
            $display("FAIL reset_ctrl {rdy,vld,ce,we,addr,wdata} got=%h exp=%h",
                     got, {4'b1000, 32'h0});
        else n_pass++;
        n_checks++;
        if (rsp_rdata !== 16'h0)
            $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata);
        else n_pass++;
        n_checks++;
        if ({b_req_ready, b_rsp_valid, b_mem_ce, b_mem_we} !== 4'b1000)
            $display("FAIL reset_dut0 got=%b exp=1000",
                     {b_req_ready, b_rsp_valid, b_mem_ce, b_mem_we});
        else n_pass++;
`ifdef MEM_RESP_IOMAP_EN
        n_checks++;
        if (hex_out !== 16'h0) $display("FAIL reset_hex got=%h exp=0000", hex_out);
        else n_pass++;
`endif
    endtask

    task automatic test_read();
        sram[16'h0010] = 16'hBEEF;
        do_access(1'b0, 16'h0010, 16'h0, 0);
    endtask

    task automatic test_write();
        do_access(1'b1, 16'h0020, 16'h1234, 0);
        do_access(1'b0, 16'h0020, 16'h0, 0);
    endtask

    task automatic test_backpressure();
        do_access(1'b0, 16'h0020, 16'h0, 5);
    endtask

    task automatic test_reset_mid_access();
        logic [35:0] got;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0030; req_wdata = 16'h0;
        @(negedge Clk);                 // first ACCESS cycle
        req_valid = 1'b0;
        @(negedge Clk);                 // second ACCESS cycle
        n_checks++;
        if (mem_ce !== 1'b1) $display("FAIL mid_access_ce got=%b exp=1", mem_ce);
        else n_pass++;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        got = {req_ready, rsp_valid, mem_ce, mem_we, mem_addr, rsp_rdata};
        n_checks++;
        if (got !== {4'b1000, 32'h0})
            $display("FAIL abort_state {rdy,vld,ce,we,addr,rdata} got=%h exp=%h",
                     got, {4'b1000, 32'h0});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({req_ready, rsp_valid, mem_ce} !== 3'b100)
                $display("FAIL abort_no_resp%0d {rdy,vld,ce} got=%b exp=100",
                         i, {req_ready, rsp_valid, mem_ce});
            else n_pass++;
        end
    endtask

    // WAIT_CYCLES=0 with req_valid and rsp_ready held high: the responder must
    // cycle accept / access / respond with a period of exactly three cycles.
    task automatic test_back_to_back();
        logic [15:0] exp_d, cur_addr;
        logic [2:0]  exp_v, got_v;
        exp_d = 16'h0; cur_addr = 16'h0;
        b_rsp_ready = 1'b1; b_req_we = 1'b0;
        for (int c = 0; c < 18; c++) begin
            case (c % 3)
                0:       exp_v = 3'b100;
                1:       exp_v = 3'b001;
                default: exp_v = 3'b010;
            endcase
            got_v = {b_req_ready, b_rsp_valid, b_mem_ce};
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL b2b_cycle%0d {rdy,vld,ce} got=%b exp=%b", c, got_v, exp_v);
            else n_pass++;
            if (c % 3 == 0) begin
                cur_addr = 16'($urandom_range(0, 255));
                b_req_valid = 1'b1; b_req_addr = cur_addr;
                b_mem_rdata = 16'($urandom);
            end else if (c % 3 == 1) begin
                n_checks++;
                if (b_mem_addr !== cur_addr)
                    $display("FAIL b2b_addr%0d got=%h exp=%h", c, b_mem_addr, cur_addr);
                else n_pass++;
                exp_d = 16'($urandom);
                b_mem_rdata = exp_d;
                b_req_addr = 16'($urandom);
            end else begin
                n_checks++;
                if (b_rsp_rdata !== exp_d)
                    $display("FAIL b2b_rdata%0d got=%h exp=%h", c, b_rsp_rdata, exp_d);
                else n_pass++;
                b_mem_rdata = 16'($urandom);
            end
            @(negedge Clk);
        end
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({b_req_ready, b_rsp_valid, b_mem_ce} !== 3'b100)
            $display("FAIL b2b_end got=%b exp=100", {b_req_ready, b_rsp_valid, b_mem_ce});
        else n_pass++;
    endtask

    task automatic test_ffff_addr();
`ifdef MEM_RESP_IOMAP_EN
        do_access(1'b1, 16'hFFFF, 16'h00A5, 0);
        sw_val_next = 16'h0042;
        do_access(1'b0, 16'hFFFF, 16'h0, 1);
        n_checks++;
        if (sram[16'hFFFF] !== 16'h0) $display("FAIL io_no_sram got=%h exp=0000", sram[16'hFFFF]);
        else n_pass++;
`else
        // Without I/O mapping, the top address is ordinary SRAM
        do_access(1'b1, 16'hFFFF, 16'h00A5, 0);
        do_access(1'b0, 16'hFFFF, 16'h0, 1);
`endif
    endtask

    task automatic test_random();
        logic        we;
        logic [15:0] addr;
        for (int i = 0; i < 30; i++) begin
            we   = 1'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 7));
            sw_val_next = 16'($urandom);
            do_access(we, addr, 16'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'h0;
        sw_val_next = 16'h0;
        @(negedge Clk);
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        test_ffff_addr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
